// File: rtl/fpu_pkg.sv
// Shared FPU definitions: divide/sqrt scheduler state encoding, the funct
// codes for div.s / sqrt.s (also decoded by iu_control), and the default
// issue-to-result latency of the iterative divide/sqrt unit.
package fpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } sched_state_t;

  localparam logic [5:0] FC_DIV_S  = 6'b000011;
  localparam logic [5:0] FC_SQRT_S = 6'b000100;

  localparam int LAT_DEFAULT = 24;

endpackage

// File: rtl/fp_lat_cnt.sv
// Loadable down-counter used to time the divide/sqrt unit latency.
// Ports:
//   clk, clr   clock, synchronous active-high clear
//   load       load load_val this cycle (wins over dec)
//   dec        decrement by one while value != 0
//   load_val   value to load
//   value      current count
//   zero       value == 0
module fp_lat_cnt #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          load,
  input  logic          dec,
  input  logic [CW-1:0] load_val,
  output logic [CW-1:0] value,
  output logic          zero
);

  always_ff @(posedge clk) begin
    if (clr)                       value <= '0;
    else if (load)                 value <= load_val;
    else if (dec && value != '0)   value <= value - 1'b1;
  end

  assign zero = (value == '0);

endmodule

// File: rtl/fp_divsqrt_sched.sv
// Scheduler for the shared iterative FP divide/sqrt unit.
// Issues div.s/sqrt.s from ID, tracks the single pending destination,
// stalls ID on structural/RAW/WAW hazards against it, and merges the
// result onto the FP regfile write port, yielding to the E3 writeback.
// Ports:
//   clk, clr                    clock, synchronous active-high reset
//   id_valid, id_div, id_sqrt   ID instruction qualifiers
//   id_fs, id_ft, id_fd         ID FP register fields
//   id_rfs, id_rft, id_wfd      ID reads fs / reads ft / writes fd
//   pipe_stall                  other ID stall sources (blocks issue)
//   e3w                         E3 writes the FP regfile this cycle
//   unit_result                 divide/sqrt unit output
//   unit_start, unit_op         start pulse and op (0 div, 1 sqrt)
//   stall_div                   stall request to ID
//   busy, pend_rn               unit occupied, pending destination
//   wb_we, wb_rn, wb_data       FP regfile write port (divider side)
module fp_divsqrt_sched
  import fpu_pkg::*;
#(
  parameter int LAT = LAT_DEFAULT,
  parameter int CW  = 8
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        id_valid,
  input  logic        id_div,
  input  logic        id_sqrt,
  input  logic [4:0]  id_fs,
  input  logic [4:0]  id_ft,
  input  logic [4:0]  id_fd,
  input  logic        id_rfs,
  input  logic        id_rft,
  input  logic        id_wfd,
  input  logic        pipe_stall,
  input  logic        e3w,
  input  logic [31:0] unit_result,
  output logic        unit_start,
  output logic        unit_op,
  output logic        stall_div,
  output logic        busy,
  output logic [4:0]  pend_rn,
  output logic        wb_we,
  output logic [4:0]  wb_rn,
  output logic [31:0] wb_data
);

  localparam logic [CW-1:0] LAT_M1 = CW'(LAT - 1);

  sched_state_t state_q;
  logic [31:0]  hold_q;
  logic [CW-1:0] cnt;
  logic         cnt_zero;
  logic         issue;
  logic         is_ds;
  logic         hazard;

  assign is_ds = id_div | id_sqrt;

  // Issue only from IDLE, so a second div/sqrt can never overlap the first.
  assign issue      = id_valid & is_ds & (state_q == ST_IDLE) & ~pipe_stall;
  assign unit_start = issue;
  assign unit_op    = issue & id_sqrt;

  assign busy = (state_q != ST_IDLE);

  // Independent of pipe_stall so the ID stall logic stays loop-free.
  assign hazard = is_ds
                | (id_rfs & (id_fs == pend_rn))
                | (id_rft & (id_ft == pend_rn))
                | (id_wfd & (id_fd == pend_rn));
  assign stall_div = id_valid & busy & hazard;

  fp_lat_cnt #(.CW(CW)) u_cnt (
    .clk      (clk),
    .clr      (clr),
    .load     (issue),
    .dec      (state_q == ST_RUN),
    .load_val (LAT_M1),
    .value    (cnt),
    .zero     (cnt_zero)
  );

  // Write port: E3 always wins; rn/data are forced to 0 when not writing.
  always_comb begin
    wb_we   = 1'b0;
    wb_rn   = '0;
    wb_data = '0;
    case (state_q)
      ST_RUN: if (cnt_zero && !e3w) begin
        wb_we   = 1'b1;
        wb_rn   = pend_rn;
        wb_data = unit_result;
      end
      ST_WAIT: if (!e3w) begin
        wb_we   = 1'b1;
        wb_rn   = pend_rn;
        wb_data = hold_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      pend_rn <= '0;
      hold_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (issue) begin
          state_q <= ST_RUN;
          pend_rn <= id_fd;
        end
        ST_RUN: if (cnt_zero) begin
          if (e3w) begin
            // Unit output is only valid for one cycle; keep it until the port frees.
            hold_q  <= unit_result;
            state_q <= ST_WAIT;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_WAIT: if (!e3w) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_divsqrt_sched.sv
module tb_fp_divsqrt_sched;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        clr;
  logic        id_valid, id_div, id_sqrt;
  logic [4:0]  id_fs, id_ft, id_fd;
  logic        id_rfs, id_rft, id_wfd;
  logic        pipe_stall, e3w;
  logic [31:0] unit_result;
  logic        unit_start, unit_op, stall_div, busy, wb_we;
  logic [4:0]  pend_rn, wb_rn;
  logic [31:0] wb_data;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  int t0;

  typedef struct {
    logic [4:0]  rn;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sbq[$];

  fp_divsqrt_sched #(.LAT(LAT), .CW(8)) dut (
    .clk(clk), .clr(clr),
    .id_valid(id_valid), .id_div(id_div), .id_sqrt(id_sqrt),
    .id_fs(id_fs), .id_ft(id_ft), .id_fd(id_fd),
    .id_rfs(id_rfs), .id_rft(id_rft), .id_wfd(id_wfd),
    .pipe_stall(pipe_stall), .e3w(e3w), .unit_result(unit_result),
    .unit_start(unit_start), .unit_op(unit_op), .stall_div(stall_div),
    .busy(busy), .pend_rn(pend_rn),
    .wb_we(wb_we), .wb_rn(wb_rn), .wb_data(wb_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    chk(nm, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_in();
    id_valid = 1'b0; id_div = 1'b0; id_sqrt = 1'b0;
    id_fs = 5'd0; id_ft = 5'd0; id_fd = 5'd0;
    id_rfs = 1'b0; id_rft = 1'b0; id_wfd = 1'b0;
    pipe_stall = 1'b0; e3w = 1'b0;
  endtask

  task automatic id_set(input logic v, input logic dv, input logic sq,
                        input logic [4:0] fs, input logic [4:0] ft, input logic [4:0] fd,
                        input logic rfs, input logic rft, input logic wfd);
    id_valid = v; id_div = dv; id_sqrt = sq;
    id_fs = fs; id_ft = ft; id_fd = fd;
    id_rfs = rfs; id_rft = rft; id_wfd = wfd;
  endtask

  // Monitor: every write on the divider port must match the scoreboard head.
  always @(negedge clk) begin : mon
    exp_t e;
    if (wb_we === 1'b1) begin
      if (sbq.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_write cyc=%0d actual rn=%0d data=%h expected no write", cyc, wb_rn, wb_data);
      end else begin
        e = sbq.pop_front();
        chk("wb_rn", {27'd0, wb_rn}, {27'd0, e.rn});
        chk("wb_data", wb_data, e.data);
        chk("wb_cycle", 32'(cyc), 32'(e.cyc));
      end
    end else begin
      chk("wb_rn_idle", {27'd0, wb_rn}, 32'd0);
      chk("wb_data_idle", wb_data, 32'd0);
    end
  end

  initial begin
    clr = 1'b1;
    idle_in();
    unit_result = 32'h0;
    repeat (3) nxt();
    // reset state
    smp();
    chkb("rst_start", unit_start, 1'b0); chkb("rst_op", unit_op, 1'b0);
    chkb("rst_stall", stall_div, 1'b0);  chkb("rst_busy", busy, 1'b0);
    chk("rst_pend", {27'd0, pend_rn}, 32'd0);
    chkb("rst_we", wb_we, 1'b0);
    nxt();
    clr = 1'b0;
    nxt();

    // A: div fd=5, RAW/WAW stalls, release after write
    unit_result = 32'hA5A5_0001;
    id_set(1'b1, 1'b1, 1'b0, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1);
    t0 = cyc;
    sbq.push_back('{5'd5, 32'hA5A5_0001, t0 + LAT});
    smp(); chkb("A_start", unit_start, 1'b1); chkb("A_op", unit_op, 1'b0);
    chkb("A_stall0", stall_div, 1'b0); chkb("A_busy0", busy, 1'b0);
    nxt();
    id_set(1'b1, 1'b0, 1'b0, 5'd5, 5'd6, 5'd7, 1'b1, 1'b1, 1'b1);
    smp(); chkb("A_raw_fs", stall_div, 1'b1); chkb("A_busy1", busy, 1'b1);
    chk("A_pend", {27'd0, pend_rn}, 32'd5); chkb("A_nostart", unit_start, 1'b0);
    nxt();
    id_set(1'b1, 1'b0, 1'b0, 5'd6, 5'd6, 5'd7, 1'b1, 1'b1, 1'b1);
    smp(); chkb("A_indep", stall_div, 1'b0);
    nxt();
    id_set(1'b1, 1'b0, 1'b0, 5'd1, 5'd5, 5'd7, 1'b0, 1'b1, 1'b1);
    smp(); chkb("A_raw_ft", stall_div, 1'b1);
    nxt();
    id_set(1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd5, 1'b0, 1'b0, 1'b1);
    smp(); chkb("A_waw_wrcyc", stall_div, 1'b1); chkb("A_we", wb_we, 1'b1);
    nxt();
    id_set(1'b1, 1'b0, 1'b0, 5'd5, 5'd6, 5'd7, 1'b1, 1'b1, 1'b1);
    smp(); chkb("A_release", stall_div, 1'b0); chkb("A_busy_end", busy, 1'b0);
    nxt();
    idle_in();
    nxt();

    // B: E3 collides for two cycles, held value written afterwards
    unit_result = 32'h1111_2222;
    id_set(1'b1, 1'b1, 1'b0, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 1'b1);
    t0 = cyc;
    sbq.push_back('{5'd9, 32'h1111_2222, t0 + LAT + 2});
    smp(); chkb("B_start", unit_start, 1'b1);
    nxt(); idle_in();
    nxt();
    nxt();
    id_set(1'b0, 1'b0, 1'b0, 5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    smp(); chkb("B_invalid_nostall", stall_div, 1'b0);
    nxt(); idle_in();
    e3w = 1'b1;
    smp(); chkb("B_e3_we0", wb_we, 1'b0); chkb("B_busy", busy, 1'b1);
    nxt();
    unit_result = 32'hDEAD_BEEF;
    smp(); chkb("B_e3_we1", wb_we, 1'b0);
    nxt();
    e3w = 1'b0;
    smp(); chkb("B_we", wb_we, 1'b1);
    nxt();
    smp(); chkb("B_busy_end", busy, 1'b0);
    nxt();

    // C: sqrt waits behind a div, then issues with its own fd
    unit_result = 32'h0000_3333;
    id_set(1'b1, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1);
    t0 = cyc;
    sbq.push_back('{5'd3, 32'h0000_3333, t0 + LAT});
    smp(); chkb("C_start", unit_start, 1'b1);
    nxt();
    id_set(1'b1, 1'b0, 1'b1, 5'd13, 5'd0, 5'd12, 1'b1, 1'b0, 1'b1);
    for (int i = 1; i <= LAT; i++) begin
      smp(); chkb("C_struct_stall", stall_div, 1'b1); chkb("C_nostart", unit_start, 1'b0);
      nxt();
    end
    unit_result = 32'h4444_5555;
    sbq.push_back('{5'd12, 32'h4444_5555, cyc + LAT});
    smp(); chkb("C_sq_nostall", stall_div, 1'b0); chkb("C_sq_start", unit_start, 1'b1);
    chkb("C_sq_op", unit_op, 1'b1);
    nxt(); idle_in();
    smp(); chk("C_pend", {27'd0, pend_rn}, 32'd12); chkb("C_busy", busy, 1'b1);
    nxt();
    repeat (3) nxt();
    smp(); chkb("C_busy_end", busy, 1'b0);
    nxt();

    // D: invalid and pipe-stalled requests do not issue
    unit_result = 32'h7777_8888;
    id_set(1'b0, 1'b1, 1'b0, 5'd1, 5'd2, 5'd20, 1'b1, 1'b1, 1'b1);
    smp(); chkb("D_invalid_noissue", unit_start, 1'b0);
    nxt();
    id_valid = 1'b1; pipe_stall = 1'b1;
    smp(); chkb("D_ps_noissue0", unit_start, 1'b0); chkb("D_ps_busy0", busy, 1'b0);
    nxt();
    smp(); chkb("D_ps_noissue1", unit_start, 1'b0); chkb("D_ps_busy1", busy, 1'b0);
    nxt();
    pipe_stall = 1'b0;
    t0 = cyc;
    sbq.push_back('{5'd20, 32'h7777_8888, t0 + LAT});
    smp(); chkb("D_issue", unit_start, 1'b1);
    nxt(); idle_in();
    repeat (LAT) nxt();
    smp(); chkb("D_busy_end", busy, 1'b0);
    nxt();

    // E: clr mid-RUN discards the in-flight result
    unit_result = 32'h9999_AAAA;
    id_set(1'b1, 1'b1, 1'b0, 5'd1, 5'd2, 5'd15, 1'b1, 1'b1, 1'b1);
    smp(); chkb("E_start", unit_start, 1'b1);
    nxt(); idle_in();
    nxt();
    clr = 1'b1;
    id_set(1'b1, 1'b0, 1'b0, 5'd15, 5'd2, 5'd7, 1'b1, 1'b1, 1'b1);
    smp(); chkb("E_busy_clrcyc", busy, 1'b1);
    nxt();
    clr = 1'b0;
    smp(); chkb("E_busy_after", busy, 1'b0); chkb("E_stall_after", stall_div, 1'b0);
    chk("E_pend_after", {27'd0, pend_rn}, 32'd0);
    nxt(); idle_in();
    repeat (6) nxt();

    while (sbq.size() != 0) begin
      exp_t e;
      e = sbq.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL missing_write actual none expected rn=%0d data=%h at cyc %0d", e.rn, e.data, e.cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
